// File: rtl/window_feed_pkg.sv
// window_feed_pkg
//   Shared types and constants for the window feed controller slice.
//   VEC_W  : bits per channel vector (LANES lanes x int8)
//   LANES  : channels per vector, power of two, must divide in_channels
//   DIM_W  : width of the in_channels/img_width/img_height config fields
//   CNT_W  : position counter width, one bit wider so W+1/H+1 fit
package window_feed_pkg;

   localparam int unsigned VEC_W     = 64;
   localparam int unsigned LANES     = 8;
   localparam int unsigned DIM_W     = 16;
   localparam int unsigned CNT_W     = DIM_W + 1;
   localparam int unsigned LANE_BITS = $clog2(LANES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic [DIM_W-1:0] channels;
      logic [DIM_W-1:0] width;
      logic [DIM_W-1:0] height;
   } cfg_t;

   // LANES is a power of two, so divisibility is a check of the low bits.
   function automatic logic cfg_is_valid(input cfg_t c);
      return (c.channels != '0)
          && (c.channels[LANE_BITS-1:0] == '0)
          && (c.width != '0)
          && (c.height != '0);
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/window_feed_ctrl_pos.sv
// feed_pos_counter
//   Nested position counter for one padded frame: ch (innermost, vectors
//   within a pixel), col (0..W+1), row (0..H+1, outermost). Advances only
//   when inc is high; clear returns all counters to zero.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     clear_i      : zero all counters (frame start)
//     inc_i        : advance by one beat
//     last_ch_i    : C/LANES-1
//     width_i      : unpadded width W
//     height_i     : unpadded height H
//     is_pad_o     : current position lies on the zero border
//     is_last_o    : current position is the final beat of the frame
module feed_pos_counter
   import window_feed_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             inc_i,
   input  logic [DIM_W-1:0] last_ch_i,
   input  logic [DIM_W-1:0] width_i,
   input  logic [DIM_W-1:0] height_i,
   output logic             is_pad_o,
   output logic             is_last_o
);

   logic [CNT_W-1:0] ch_q,  ch_d;
   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] row_q, row_d;
   logic [CNT_W-1:0] ch_max, col_max, row_max;

   assign ch_max  = {1'b0, last_ch_i};
   assign col_max = {1'b0, width_i}  + CNT_W'(1);
   assign row_max = {1'b0, height_i} + CNT_W'(1);

   always_comb begin
      ch_d  = ch_q;
      col_d = col_q;
      row_d = row_q;
      if (clear_i) begin
         ch_d  = '0;
         col_d = '0;
         row_d = '0;
      end else if (inc_i) begin
         if (ch_q == ch_max) begin
            ch_d = '0;
            if (col_q == col_max) begin
               col_d = '0;
               row_d = (row_q == row_max) ? '0 : row_q + CNT_W'(1);
            end else begin
               col_d = col_q + CNT_W'(1);
            end
         end else begin
            ch_d = ch_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_q  <= '0;
         col_q <= '0;
         row_q <= '0;
      end else begin
         ch_q  <= ch_d;
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign is_pad_o  = (row_q == '0) || (row_q == row_max)
                   || (col_q == '0) || (col_q == col_max);
   assign is_last_o = (row_q == row_max) && (col_q == col_max) && (ch_q == ch_max);

endmodule

// File: rtl/window_feed_ctrl.sv
// window_feed_ctrl
//   Sequences one feature-map frame into the 3x3 window datapath, inserting
//   a one-pixel zero border around the unpadded channel-vector stream and
//   emitting beats in padded raster order (ch, then col, then row).
//   Optional macro WINDOW_FEED_PERF_EN adds perf_starve/perf_stall/perf_beats.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     start                    : one-cycle pulse, latch config and begin frame
//     cfg_in_channels/width/height : frame config (C, W, H)
//     in_valid/in_data/in_ready: upstream vector stream
//     out_ready                : downstream enable
//     pixel_out/data_valid     : registered beat to the window
//     win_in_channels          : latched C
//     win_img_width            : latched W+2
//     busy/done                : frame in progress / end-of-frame pulse
//     cfg_err                  : pulse after a rejected start
//     perf_*                   : saturating event counters (macro only)
module window_feed_ctrl
   import window_feed_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIM_W-1:0] cfg_in_channels,
   input  logic [DIM_W-1:0] cfg_img_width,
   input  logic [DIM_W-1:0] cfg_img_height,
   input  logic             in_valid,
   input  logic [VEC_W-1:0] in_data,
   output logic             in_ready,
   input  logic             out_ready,
   output logic [VEC_W-1:0] pixel_out,
   output logic             data_valid,
   output logic [DIM_W-1:0] win_in_channels,
   output logic [DIM_W-1:0] win_img_width,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
`ifdef WINDOW_FEED_PERF_EN
   ,
   output logic [31:0]      perf_starve,
   output logic [31:0]      perf_stall,
   output logic [31:0]      perf_beats
`endif
);

   state_e           state_q, state_d;
   cfg_t             cfg_q, cfg_d, start_cfg;
   logic [DIM_W-1:0] last_ch_q, last_ch_d;
   logic [DIM_W-1:0] win_w_q, win_w_d;
   logic [VEC_W-1:0] pix_q, pix_d;
   logic             dv_q, dv_d;
   logic             cfg_err_q, cfg_err_d;

   logic             cfg_ok, accept, reject, in_run, issue;
   logic             is_pad, is_last;

   assign start_cfg = '{channels: cfg_in_channels,
                        width:    cfg_img_width,
                        height:   cfg_img_height};
   assign cfg_ok    = cfg_is_valid(start_cfg);
   assign accept    = (state_q == IDLE) && start && cfg_ok;
   assign reject    = (state_q == IDLE) && start && !cfg_ok;
   assign in_run    = (state_q == RUN);

   // Border beats need only downstream space; interior beats also need data.
   assign issue     = in_run && out_ready && (is_pad || in_valid);
   assign in_ready  = in_run && !is_pad && out_ready;

   feed_pos_counter u_pos (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (accept),
      .inc_i     (issue),
      .last_ch_i (last_ch_q),
      .width_i   (cfg_q.width),
      .height_i  (cfg_q.height),
      .is_pad_o  (is_pad),
      .is_last_o (is_last)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (issue && is_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pix_d     = pix_q;
      dv_d      = issue;
      cfg_err_d = reject;
      cfg_d     = cfg_q;
      last_ch_d = last_ch_q;
      win_w_d   = win_w_q;
      if (issue) begin
         pix_d = is_pad ? '0 : in_data;
      end
      if (accept) begin
         cfg_d     = start_cfg;
         last_ch_d = (cfg_in_channels >> LANE_BITS) - DIM_W'(1);
         win_w_d   = cfg_img_width + DIM_W'(2);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cfg_q     <= '0;
         last_ch_q <= '0;
         win_w_q   <= '0;
         pix_q     <= '0;
         dv_q      <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         last_ch_q <= last_ch_d;
         win_w_q   <= win_w_d;
         pix_q     <= pix_d;
         dv_q      <= dv_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign pixel_out       = pix_q;
   assign data_valid      = dv_q;
   assign cfg_err         = cfg_err_q;
   assign win_in_channels = cfg_q.channels;
   assign win_img_width   = win_w_q;
   // DONE is entered on the last issue, so it lines up with the last beat.
   assign busy            = (state_q != IDLE);
   assign done            = (state_q == DONE);

`ifdef WINDOW_FEED_PERF_EN
   logic [31:0] starve_q, starve_d;
   logic [31:0] stall_q,  stall_d;
   logic [31:0] beats_q,  beats_d;

   always_comb begin
      starve_d = starve_q;
      stall_d  = stall_q;
      beats_d  = beats_q;
      if (accept) begin
         starve_d = '0;
         stall_d  = '0;
         beats_d  = '0;
      end else begin
         if (in_run && !is_pad && out_ready && !in_valid) starve_d = sat_inc32(starve_q);
         if (in_run && !out_ready)                        stall_d  = sat_inc32(stall_q);
         if (issue)                                       beats_d  = sat_inc32(beats_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
         stall_q  <= '0;
         beats_q  <= '0;
      end else begin
         starve_q <= starve_d;
         stall_q  <= stall_d;
         beats_q  <= beats_d;
      end
   end

   assign perf_starve = starve_q;
   assign perf_stall  = stall_q;
   assign perf_beats  = beats_q;
`endif

endmodule
